// File: rtl/cordic_vec_rot_serial_if.sv
// Request/result bundle for the serial CORDIC engine: ready/valid on both sides,
// user tag and mode travel with the vector.
interface cordic_vec_rot_serial_if #(
  parameter int XY_WDT  = 18,
  parameter int TAG_WDT = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      mode;
  logic [TAG_WDT-1:0]        tag;
  logic signed [XY_WDT-1:0]  xin;
  logic signed [XY_WDT-1:0]  yin;
  logic signed [XY_WDT+1:0]  zin;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_mode;
  logic [TAG_WDT-1:0]        out_tag;
  logic signed [XY_WDT:0]    xout;
  logic signed [XY_WDT:0]    yout;
  logic signed [XY_WDT+1:0]  zout;

  modport master (
    output in_valid, mode, tag, xin, yin, zin, out_ready,
    input  in_ready, out_valid, out_mode, out_tag, xout, yout, zout
  );

  modport slave (
    input  in_valid, mode, tag, xin, yin, zin, out_ready,
    output in_ready, out_valid, out_mode, out_tag, xout, yout, zout
  );
endinterface

// File: rtl/cordic_vec_rot_serial.sv
// Serial CORDIC, vectoring or rotation per request; result valid N+3 cycles after accept.
// One job in flight: in_ready only in IDLE, result held in DONE until out_ready (with en).
module cordic_vec_rot_serial #(
  parameter int N       = 13,
  parameter int XY_WDT  = 18,
  parameter int TAG_WDT = 2
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    en,
  cordic_vec_rot_serial_if.slave bus
);
  localparam int W  = XY_WDT + 2;
  localparam int OW = XY_WDT + 1;
  localparam int CW = $clog2(N);

  localparam logic signed [W-1:0] PI          = {2'b01, {XY_WDT{1'b0}}};
  localparam logic signed [W-1:0] NEG_PI      = {2'b11, {XY_WDT{1'b0}}};
  localparam logic signed [W-1:0] HALF_PI     = {3'b001, {(XY_WDT-1){1'b0}}};
  localparam logic signed [W-1:0] NEG_HALF_PI = {3'b111, {(XY_WDT-1){1'b0}}};

  localparam logic signed [2*W-1:0] SAT_HI = {{(2*W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_LO = {{(2*W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic signed [W-1:0] atan_q(input int i);
    real r;
    r = $atan(2.0 ** (-i)) / 3.14159265358979323846 * (2.0 ** XY_WDT);
    return W'($rtoi(r + 0.5));
  endfunction

  function automatic logic signed [2*W-1:0] kq_calc();
    real k;
    k = 1.0;
    for (int i = 0; i < N; i++) k = k / $sqrt(1.0 + 2.0 ** (-2 * i));
    return (2*W)'($rtoi(k * (2.0 ** XY_WDT) + 0.5));
  endfunction

  localparam logic signed [2*W-1:0] KQ = kq_calc();

  // Floor-shifted gain product clipped into the output width.
  function automatic logic signed [OW-1:0] sat(input logic signed [2*W-1:0] p);
    logic signed [2*W-1:0] s;
    s = p >>> XY_WDT;
    if (s > SAT_HI)      return {1'b0, {(OW-1){1'b1}}};
    else if (s < SAT_LO) return {1'b1, {(OW-1){1'b0}}};
    else                 return s[OW-1:0];
  endfunction

  logic signed [W-1:0] atan_tbl [N];
  for (genvar g = 0; g < N; g++) begin : g_atan
    localparam logic signed [W-1:0] A = atan_q(g);
    assign atan_tbl[g] = A;
  end

  typedef enum logic [2:0] {IDLE, PRE, ITER, COMP, DONE} state_t;

  state_t               state;
  logic signed [W-1:0]  x, y, z;
  logic                 mode_r;
  logic [TAG_WDT-1:0]   tag_r;
  logic [CW-1:0]        iter;

  logic signed [W-1:0]   xs, ys, atan_cur;
  logic                  ccw;
  logic signed [2*W-1:0] xp, yp;

  assign xs       = x >>> iter;
  assign ys       = y >>> iter;
  assign atan_cur = atan_tbl[iter];
  // Counter-clockwise step: vectoring chases y toward 0, rotation chases z toward 0.
  assign ccw      = mode_r ? ~z[W-1] : y[W-1];
  assign xp       = $signed({{W{x[W-1]}}, x}) * KQ;
  assign yp       = $signed({{W{y[W-1]}}, y}) * KQ;

  assign bus.in_ready = en && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      z             <= '0;
      mode_r        <= 1'b0;
      tag_r         <= '0;
      iter          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_mode  <= 1'b0;
      bus.out_tag   <= '0;
      bus.xout      <= '0;
      bus.yout      <= '0;
      bus.zout      <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x      <= {{2{bus.xin[XY_WDT-1]}}, bus.xin};
            y      <= {{2{bus.yin[XY_WDT-1]}}, bus.yin};
            z      <= bus.mode ? bus.zin : '0;
            mode_r <= bus.mode;
            tag_r  <= bus.tag;
            iter   <= '0;
            state  <= PRE;
          end
        end
        PRE: begin
          // Fold into the right half-plane so the iterations converge.
          if (!mode_r) begin
            if (x[W-1]) begin
              x <= -x;
              y <= -y;
              z <= y[W-1] ? NEG_PI : PI;
            end else begin
              z <= '0;
            end
          end else if (z > HALF_PI) begin
            z <= z - PI;
            x <= -x;
            y <= -y;
          end else if (z < NEG_HALF_PI) begin
            z <= z + PI;
            x <= -x;
            y <= -y;
          end
          state <= ITER;
        end
        ITER: begin
          if (ccw) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - atan_cur;
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + atan_cur;
          end
          if (iter == CW'(N - 1)) begin
            iter  <= '0;
            state <= COMP;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        COMP: begin
          bus.xout      <= sat(xp);
          bus.yout      <= mode_r ? sat(yp) : '0;
          bus.zout      <= z;
          bus.out_mode  <= mode_r;
          bus.out_tag   <= tag_r;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_vec_rot_serial.sv
// Bench for cordic_vec_rot_serial: directed vectors, backpressure, en stalls, mid-job
// reset and random jobs, all checked against an integer model of the CORDIC rules.
module tb_cordic_vec_rot_serial;
  localparam int    XW   = 18;
  localparam int    NI   = 13;
  localparam int    W    = XW + 2;
  localparam longint PIQ = 262144;
  // Residual angle after NI steps can reach atan(2^-(NI-1)), about 20 phase LSBs.
  localparam longint TOL = 32;

  logic clk = 1'b0;
  logic reset;
  logic en;

  cordic_vec_rot_serial_if #(.XY_WDT(XW), .TAG_WDT(2)) bus ();

  cordic_vec_rot_serial #(.N(NI), .XY_WDT(XW), .TAG_WDT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint atan_t [NI];
  longint kq;

  typedef struct {
    bit     m;
    longint x, y, z;
    longint ex, ey, ez;
  } vec_t;
  vec_t vt [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input longint act, input longint exp);
    longint d;
    total++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > TOL) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, TOL);
    end
  endtask

  function automatic longint wrapw(input longint v);
    longint m;
    m = v & ((longint'(1) << W) - 1);
    if (m >= (longint'(1) << (W - 1))) m = m - (longint'(1) << W);
    return m;
  endfunction

  function automatic longint satq(input longint v);
    longint s;
    s = v >>> XW;
    if (s > 262143) return 262143;
    if (s < -262144) return -262144;
    return s;
  endfunction

  // Fold, rotate by +/-atan(2^-i) NI times, then apply the gain constant.
  task automatic model(input bit m, input longint xi, yi, zi,
                       output longint xo, yo, zo);
    longint x, y, z, xn, yn;
    bit d;
    x = xi;
    y = yi;
    z = m ? zi : 0;
    if (!m) begin
      if (x < 0) begin
        z = (y >= 0) ? PIQ : -PIQ;
        x = -x;
        y = -y;
      end
    end else if (z > PIQ / 2) begin
      z = z - PIQ; x = -x; y = -y;
    end else if (z < -PIQ / 2) begin
      z = z + PIQ; x = -x; y = -y;
    end
    for (int i = 0; i < NI; i++) begin
      d = m ? (z >= 0) : (y < 0);
      if (d) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = wrapw(z - atan_t[i]);
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = wrapw(z + atan_t[i]);
      end
      x = xn;
      y = yn;
    end
    xo = satq(x * kq);
    yo = m ? satq(y * kq) : 0;
    zo = z;
  endtask

  task automatic run_job(input string nm, input bit m, input bit [1:0] tg,
                         input longint xi, yi, zi, input bit rand_en, input int hold,
                         output longint xo, yo, zo);
    longint ex, ey, ez;
    longint sx, sy, sz;
    int     k, lows, waitc, unstable, rdy_seen;
    model(m, xi, yi, zi, ex, ey, ez);
    en = 1'b1;
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    chk({nm, ".in_ready"}, longint'(bus.in_ready), 1);
    bus.mode     = m;
    bus.tag      = tg;
    bus.xin      = XW'(xi);
    bus.yin      = XW'(yi);
    bus.zin      = W'(zi);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    k = 1;
    lows = 0;
    while (!bus.out_valid && k < 400) begin
      en = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!en) lows++;
      tick();
      k++;
    end
    en = 1'b1;
    chk({nm, ".latency"}, k, NI + 3 + lows);
    chk({nm, ".in_ready_done"}, longint'(bus.in_ready), 0);
    sx = bus.xout; sy = bus.yout; sz = bus.zout;
    unstable = 0;
    rdy_seen = 0;
    for (int c = 0; c < hold; c++) begin
      bus.in_valid = 1'b1;
      bus.xin      = XW'(12345);
      tick();
      if (!bus.out_valid || bus.xout != sx || bus.yout != sy || bus.zout != sz) unstable++;
      if (bus.in_ready) rdy_seen++;
    end
    bus.in_valid = 1'b0;
    if (hold > 0) begin
      chk({nm, ".hold_stable"}, unstable, 0);
      chk({nm, ".hold_in_ready"}, rdy_seen, 0);
    end
    xo = bus.xout;
    yo = bus.yout;
    zo = bus.zout;
    chk({nm, ".x"}, xo, ex);
    chk({nm, ".y"}, yo, ey);
    chk({nm, ".z"}, zo, ez);
    chk({nm, ".tag"}, longint'(bus.out_tag), longint'(tg));
    chk({nm, ".mode"}, longint'(bus.out_mode), longint'(m));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, ".valid_drop"}, longint'(bus.out_valid), 0);
    chk({nm, ".in_ready_after"}, longint'(bus.in_ready), 1);
  endtask

  initial begin
    longint xo, yo, zo;
    int     seen;
    real    kr;

    for (int i = 0; i < NI; i++)
      atan_t[i] = longint'($rtoi($atan(2.0 ** (-i)) / 3.14159265358979323846 * (2.0 ** XW) + 0.5));
    kr = 1.0;
    for (int i = 0; i < NI; i++) kr = kr / $sqrt(1.0 + 2.0 ** (-2 * i));
    kq = longint'($rtoi(kr * (2.0 ** XW) + 0.5));

    vt[0] = '{0,   65536,       0,       0,   65536,      0,       0};
    vt[1] = '{0,  -65536,       0,       0,   65536,      0,  262144};
    vt[2] = '{0,       0,  -65536,       0,   65536,      0, -131072};
    vt[3] = '{0, -131072, -131072,       0,  185364,      0, -196608};
    vt[4] = '{0,  131071,  131071,   77777,  185362,      0,   65536};
    vt[5] = '{1,   65536,       0,  131072,       0,  65536,       0};
    vt[6] = '{1,   65536,       0, -262144,  -65536,      0,       0};
    vt[7] = '{1,   65536,       0,  262144,  -65536,      0,       0};
    vt[8] = '{1,       0,   65536, -131072,   65536,      0,       0};
    vt[9] = '{1,   65536,       0,       0,   65536,      0,       0};

    reset = 1'b1;
    en    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode = 1'b0;
    bus.tag  = '0;
    bus.xin  = '0;
    bus.yin  = '0;
    bus.zin  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset.out_valid", longint'(bus.out_valid), 0);
    chk("reset.xout", longint'(bus.xout), 0);
    chk("reset.yout", longint'(bus.yout), 0);
    chk("reset.zout", longint'(bus.zout), 0);
    chk("reset.out_tag", longint'(bus.out_tag), 0);
    chk("reset.out_mode", longint'(bus.out_mode), 0);
    chk("reset.in_ready", longint'(bus.in_ready), 1);
    en = 1'b0;
    #1;
    chk("en_low.in_ready", longint'(bus.in_ready), 0);
    en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_job($sformatf("vec%0d", i), vt[i].m, (i == 0) ? 2'd2 : 2'(i), vt[i].x, vt[i].y, vt[i].z,
              1'b0, 0, xo, yo, zo);
      chk_tol($sformatf("vec%0d.xf", i), xo, vt[i].ex);
      chk_tol($sformatf("vec%0d.yf", i), yo, vt[i].ey);
      chk_tol($sformatf("vec%0d.zf", i), zo, vt[i].ez);
    end

    run_job("bp", 1'b0, 2'd1, -100000, 50000, 0, 1'b0, 10, xo, yo, zo);
    run_job("en_tog", 1'b1, 2'd3, 90000, -40000, 200000, 1'b1, 2, xo, yo, zo);

    // Abort a job inside ITER; nothing from it may surface.
    bus.mode = 1'b0; bus.tag = 2'd1;
    bus.xin = XW'(70000); bus.yin = XW'(30000); bus.zin = '0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("iter.in_ready", longint'(bus.in_ready), 0);
    reset = 1'b1;
    en    = 1'b0;
    tick();
    reset = 1'b0;
    en    = 1'b1;
    #1;
    chk("rst_mid.out_valid", longint'(bus.out_valid), 0);
    chk("rst_mid.xout", longint'(bus.xout), 0);
    chk("rst_mid.yout", longint'(bus.yout), 0);
    chk("rst_mid.zout", longint'(bus.zout), 0);
    chk("rst_mid.out_tag", longint'(bus.out_tag), 0);
    chk("rst_mid.in_ready", longint'(bus.in_ready), 1);
    seen = 0;
    for (int c = 0; c < NI + 6; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("rst_mid.no_output", seen, 0);
    run_job("after_rst", 1'b1, 2'd2, -50000, 20000, -150000, 1'b0, 0, xo, yo, zo);

    for (int j = 0; j < 40; j++) begin
      run_job($sformatf("rnd%0d", j), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              longint'($urandom_range(0, 262143)) - 131072,
              longint'($urandom_range(0, 262143)) - 131072,
              longint'($urandom_range(0, 524287)) - 262143,
              (j % 3) == 0, int'($urandom_range(0, 3)), xo, yo, zo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
